cim_host_bridge: RTL
====================

CIM_HOST_BRIDGE -- requirements
Module: cim_host_bridge

Interface
REQ-001 SHALL have parameter REG_ADDR, default 8, register address width.
REQ-002 SHALL have parameter REG_DATA_WIDTH, default 32, register data and command/response word width.
REQ-003 SHALL have parameter IN_WIDTH, default 192, input-FIFO word width (6 command words).
REQ-004 SHALL have parameter OUT_WIDTH, default 64, output-FIFO word width (2 response words).
REQ-005 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports cmd_data in 32, cmd_valid in 1, cmd_ready out 1 as the host command stream; a word transfers when valid and ready are both high.
REQ-008 SHALL have ports rsp_data out 32, rsp_valid out 1, rsp_ready in 1 as the host response stream; same transfer rule.
REQ-009 SHALL have ports a_reg out 8, d_reg out 32, reg_en out 1 as the register-write master.
REQ-010 SHALL have ports din_inputfifo out 192, WR_EN_inputfifo out 1, full_inputfifo in 1 as the input-FIFO writer.
REQ-011 SHALL have ports dout_outputfifo in 64, RD_EN_outputfifo out 1, empty_outputfifo in 1 as the output-FIFO reader; read data is valid on the cycle after RD_EN.

Function
REQ-012 SHALL decode the header word by opcode cmd_data[31:30]: 00 REGWR, 01 LOAD, 10 READ, 11 reserved.
REQ-013 SHALL use FSM states IDLE, REG_DATA, REG_WR, LOAD_COL, LOAD_PUSH, RD_POP, RD_CAP, RD_LO, RD_HI.
REQ-014 SHALL drive cmd_ready high only in IDLE, REG_DATA and LOAD_COL.
REQ-015 SHALL, for a REGWR header, latch a_reg = header[7:0], go to REG_DATA, latch the next word into d_reg, then enter REG_WR.
REQ-016 SHALL assert reg_en for exactly one cycle in REG_WR, with a_reg and d_reg stable during that cycle, then return to IDLE.
REQ-017 SHALL, for a LOAD header, collect the next 6 words; word k SHALL fill din_inputfifo[32k+31:32k].
REQ-018 SHALL, in LOAD_PUSH, hold din_inputfifo and pulse WR_EN_inputfifo for one cycle on the first cycle full_inputfifo is low, then return to IDLE; it SHALL wait indefinitely while full.
REQ-019 SHALL, for a READ header, load a 16-bit counter from header[15:0]; a count of 0 SHALL return to IDLE with no FIFO read and no response.
REQ-020 SHALL, in RD_POP, pulse RD_EN_outputfifo for one cycle only when empty_outputfifo is low, capture dout_outputfifo in RD_CAP, and never read while empty.
REQ-021 SHALL present the captured bits [31:0] in RD_LO and bits [63:32] in RD_HI, holding rsp_valid and rsp_data stable until rsp_ready is high.
REQ-022 SHALL, after the RD_HI transfer, decrement the counter and go to RD_POP if it is nonzero, else to IDLE.
REQ-023 SHALL consume a reserved header in one cycle with no side effects.
REQ-024 SHALL never assert reg_en, WR_EN_inputfifo and RD_EN_outputfifo in the same cycle.

Reset
REQ-025 SHALL, while rst is low, force state IDLE and set cmd_ready, rsp_valid, reg_en, WR_EN_inputfifo and RD_EN_outputfifo to 0, and a_reg, d_reg, din_inputfifo, rsp_data and the counter to 0.
REQ-026 SHALL, on reset mid-operation, discard any partial LOAD, pending register write or READ count with no FIFO or register pulse, and raise cmd_ready on the first clock after rst is released.

Structure
REQ-027 SHALL place the opcode constants, the state encoding and the LOAD word count (6) in shared package cim_host_pkg.
REQ-028 SHALL be a single module with no sub-modules; the 6-word packer and the 2-word splitter are inline shift/select logic.

Verification
REQ-029 SHALL cover a register write: header 0x0000_0004 then 0x8000_0011 -> one reg_en pulse with a_reg=0x04 and d_reg=0x8000_0011.
REQ-030 SHALL cover a load with FIFO full: LOAD header then words 0..5 = 0x1..0x6, full_inputfifo high for 10 cycles -> no write while full, then one WR_EN with din = {0x6,...,0x1}.
REQ-031 SHALL cover a read of 2 with an initially empty FIFO: READ count 2, FIFO empty for 5 cycles, then 0xAAAA_BBBB_CCCC_DDDD and 0x1111_2222_3333_4444 -> responses 0xCCCCDDDD, 0xAAAABBBB, 0x33334444, 0x11112222.
REQ-032 SHALL cover response backpressure: rsp_ready held low for 7 cycles during RD_LO -> rsp_data stable, no extra RD_EN pulse.
REQ-033 SHALL cover a READ with count 0 -> no RD_EN, no rsp_valid, and cmd_ready high on the next cycle.
REQ-034 SHALL cover a reset during LOAD after 3 words -> no WR_EN, and a following full LOAD writes only the new data.

Source files
------------

// File: rtl/cim_host_pkg.sv
// Shared definitions for the CIM host bridge: command opcodes, FSM state
// encoding and the number of command words packed into one input-FIFO word.
package cim_host_pkg;

    // Header opcode carried in cmd_data[31:30]
    typedef enum logic [1:0] {
        OP_REGWR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_e;

    // Bridge control states
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        REG_DATA  = 4'd1,
        REG_WR    = 4'd2,
        LOAD_COL  = 4'd3,
        LOAD_PUSH = 4'd4,
        RD_POP    = 4'd5,
        RD_CAP    = 4'd6,
        RD_LO     = 4'd7,
        RD_HI     = 4'd8
    } state_e;

    // Command words gathered per LOAD before one input-FIFO write
    localparam int LOAD_WORDS = 6;

    // States in which the command stream is accepted
    function automatic logic accepts_cmd(state_e s);
        return (s == IDLE) || (s == REG_DATA) || (s == LOAD_COL);
    endfunction

endpackage

// File: rtl/cim_host_bridge.sv
// Host bridge: decodes a 32-bit command stream into register writes,
// 6-word input-FIFO loads and counted output-FIFO reads that are returned
// to the host as pairs of 32-bit response words.
module cim_host_bridge
    import cim_host_pkg::*;
#(
    parameter int REG_ADDR       = 8,
    parameter int REG_DATA_WIDTH = 32,
    parameter int IN_WIDTH       = 192,
    parameter int OUT_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    // host command stream
    input  logic [REG_DATA_WIDTH-1:0] cmd_data,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    // host response stream
    output logic [REG_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    // register-write master
    output logic [REG_ADDR-1:0]       a_reg,
    output logic [REG_DATA_WIDTH-1:0] d_reg,
    output logic                      reg_en,
    // input-FIFO writer
    output logic [IN_WIDTH-1:0]       din_inputfifo,
    output logic                      WR_EN_inputfifo,
    input  logic                      full_inputfifo,
    // output-FIFO reader
    input  logic [OUT_WIDTH-1:0]      dout_outputfifo,
    output logic                      RD_EN_outputfifo,
    input  logic                      empty_outputfifo
);

    localparam int IDX_W = $clog2(LOAD_WORDS);

    state_e                    state_reg, state_next;
    logic [IDX_W-1:0]          word_idx_reg;
    logic [15:0]               count_reg;
    logic [OUT_WIDTH-1:0]      cap_reg;
    logic                      live_reg;
    logic [REG_DATA_WIDTH-1:0] lane_reg [LOAD_WORDS];
    logic                      cmd_fire;
    opcode_e                   op;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign op       = opcode_e'(cmd_data[31:30]);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake/strobe outputs
    always_comb begin
        state_next       = state_reg;
        cmd_ready        = live_reg && accepts_cmd(state_reg);
        reg_en           = 1'b0;
        WR_EN_inputfifo  = 1'b0;
        RD_EN_outputfifo = 1'b0;
        rsp_valid        = 1'b0;
        rsp_data         = cap_reg[REG_DATA_WIDTH-1:0];
        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    case (op)
                        OP_REGWR: state_next = REG_DATA;
                        OP_LOAD:  state_next = LOAD_COL;
                        // a zero count is consumed without touching the FIFO
                        OP_READ:  state_next = (cmd_data[15:0] != 16'd0) ? RD_POP : IDLE;
                        default:  state_next = IDLE;
                    endcase
                end
            end
            REG_DATA: begin
                if (cmd_fire) state_next = REG_WR;
            end
            REG_WR: begin
                reg_en     = 1'b1;
                state_next = IDLE;
            end
            LOAD_COL: begin
                if (cmd_fire && (word_idx_reg == IDX_W'(LOAD_WORDS - 1))) begin
                    state_next = LOAD_PUSH;
                end
            end
            LOAD_PUSH: begin
                if (!full_inputfifo) begin
                    WR_EN_inputfifo = 1'b1;
                    state_next      = IDLE;
                end
            end
            RD_POP: begin
                if (!empty_outputfifo) begin
                    RD_EN_outputfifo = 1'b1;
                    state_next       = RD_CAP;
                end
            end
            RD_CAP: begin
                state_next = RD_LO;
            end
            RD_LO: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = RD_HI;
            end
            RD_HI: begin
                rsp_valid = 1'b1;
                rsp_data  = cap_reg[REG_DATA_WIDTH +: REG_DATA_WIDTH];
                if (rsp_ready) state_next = (count_reg == 16'd1) ? IDLE : RD_POP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: address/data latches, word index, read count, capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_reg     <= 1'b0;
            a_reg        <= '0;
            d_reg        <= '0;
            word_idx_reg <= '0;
            count_reg    <= '0;
            cap_reg      <= '0;
        end else begin
            // holds cmd_ready low until the first clock after reset release
            live_reg <= 1'b1;
            if (state_reg == IDLE && cmd_fire && op == OP_REGWR) begin
                a_reg <= cmd_data[REG_ADDR-1:0];
            end
            if (state_reg == REG_DATA && cmd_fire) begin
                d_reg <= cmd_data;
            end
            if (state_reg == IDLE && cmd_fire && op == OP_LOAD) begin
                word_idx_reg <= '0;
            end else if (state_reg == LOAD_COL && cmd_fire) begin
                word_idx_reg <= word_idx_reg + IDX_W'(1);
            end
            if (state_reg == IDLE && cmd_fire && op == OP_READ) begin
                count_reg <= cmd_data[15:0];
            end else if (state_reg == RD_HI && rsp_ready) begin
                count_reg <= count_reg - 16'd1;
            end
            if (state_reg == RD_CAP) begin
                cap_reg <= dout_outputfifo;
            end
        end
    end

    // Packer: command word k of a LOAD lands in lane k of din_inputfifo
    for (genvar gi = 0; gi < LOAD_WORDS; gi++) begin : g_lane
        // Capture the command word addressed to this lane
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lane_reg[gi] <= '0;
            end else if (state_reg == LOAD_COL && cmd_fire && word_idx_reg == IDX_W'(gi)) begin
                lane_reg[gi] <= cmd_data;
            end
        end
        assign din_inputfifo[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = lane_reg[gi];
    end

endmodule
